// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: PC-source encodings, fetch FSM
// states, the default reset vector and instruction field positions.
package mips_pkg;

  // Next-PC source as presented by the control unit with ex_done.
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,  // sequential, or conditional branch qualified by branch_taken
    PC_JUMP = 2'b01,  // j / jal pseudo-direct target
    PC_JR   = 2'b10,  // jr / jalr register target
    PC_RSVD = 2'b11   // treated exactly like PC_SEQ
  } pcSrc_e;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_ISSUE = 2'b10,
    S_ERR   = 2'b11
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  // Jump-index field of a J-type instruction.
  localparam int JIDX_HI = 25;
  localparam int JIDX_LO = 0;
  localparam int JIDX_W  = JIDX_HI - JIDX_LO + 1;

  // Pseudo-direct jump target: upper nibble of pc+4, word index, byte offset 0.
  function automatic logic [31:0] jumpTarget(input logic [31:0]       pcPlus4,
                                             input logic [JIDX_W-1:0] jumpIndex);
    return {pcPlus4[31:28], jumpIndex, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Purely combinational next-PC selection for the fetch unit, plus a flag that
// the selected target is not word aligned.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0]        pcPlus4,
  input  logic [JIDX_W-1:0]  jumpIndex,
  input  logic [1:0]         pcSrc,
  input  logic               branchTaken,
  input  logic signed [31:0] branchOff,
  input  logic [31:0]        jrTarget,
  output logic [31:0]        npc,
  output logic               misaligned
);

  // Word offset to byte offset; wraps modulo 2^32 like the adder below.
  logic signed [31:0] branchDisp;
  assign branchDisp = branchOff <<< 2;

  // Select the next PC from the retired instruction's control outcome.
  always_comb begin
    npc = pcPlus4;
    case (pcSrc)
      PC_JUMP: npc = jumpTarget(pcPlus4, jumpIndex);
      PC_JR:   npc = jrTarget;
      default: npc = branchTaken ? (pcPlus4 + $unsigned(branchDisp)) : pcPlus4;
    endcase
  end

  // Only a register target can really be misaligned, but checking the final
  // value keeps the rule in one place.
  assign misaligned = |npc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake from a
// variable-latency instruction memory, holds the word for decode until the core
// retires it, then steers to the next PC. Misaligned register targets and memory
// timeouts park the unit in a sticky error state until reset.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               ex_done,
  input  logic [1:0]         pc_src,
  input  logic               branch_taken,
  input  logic signed [31:0] branch_off,
  input  logic [31:0]        jr_target,
  output logic               fetch_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetchState_e      state;
  logic [CNT_W-1:0] waitCnt;
  logic [31:0]      npc;
  logic             npcMisaligned;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  npc_calc uNpc (
    .pcPlus4     (pc_plus4),
    .jumpIndex   (instr[JIDX_HI:JIDX_LO]),
    .pcSrc       (pc_src),
    .branchTaken (branch_taken),
    .branchOff   (branch_off),
    .jrTarget    (jr_target),
    .npc         (npc),
    .misaligned  (npcMisaligned)
  );

  // Fetch FSM with registered handshake/status outputs, PC, instruction latch
  // and the no-ack watchdog counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      waitCnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          imem_req <= 1'b1;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            waitCnt     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end else if (waitCnt == CNT_LAST) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (ex_done) begin
            instr_valid <= 1'b0;
            if (npcMisaligned) begin
              // PC stays at the faulting instruction for post-mortem.
              fetch_err <= 1'b1;
              state     <= S_ERR;
            end else begin
              pc       <= npc;
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
          state       <= S_ERR;
        end
      endcase
    end
  end

endmodule
